// File: rtl/cam_stream_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : cam_stream_gen_if
// Description : Camera-style video bus (vsync/href/data) plus frame control
//               handshake between the frame source and its consumer.
//               frame_cnt exists only when CAM_STREAM_GEN_FRAME_CNT_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
interface cam_stream_gen_if;
    logic       enable;
    logic       vsync;
    logic       href;
    logic [7:0] data;
    logic       frame_done;
    logic       busy;
`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
    logic [7:0] frame_cnt;

    modport master (input enable, output vsync, href, data, frame_done, busy, frame_cnt);
    modport slave  (output enable, input vsync, href, data, frame_done, busy, frame_cnt);
`else
    modport master (input enable, output vsync, href, data, frame_done, busy);
    modport slave  (output enable, input vsync, href, data, frame_done, busy);
`endif
endinterface
`default_nettype wire

// File: rtl/cam_stream_gen.sv
`default_nettype none
// ============================================================================
// Module      : cam_stream_gen
// Description : OV7670-style frame source producing vsync/href/data framing
//               with a deterministic (byte + line [+ frame]) mod 256 pattern.
//               Optional macro CAM_STREAM_GEN_FRAME_CNT_EN adds frame_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module cam_stream_gen #(
    parameter int H_ACTIVE   = 1280,
    parameter int H_BLANK    = 288,
    parameter int V_ACTIVE   = 480,
    parameter int VSYNC_LEN  = 1568,
    parameter int VBACK_LEN  = 1568,
    parameter int VFRONT_LEN = 1568
) (
    input  wire logic        clk,
    input  wire logic        reset,
    cam_stream_gen_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_VSYNC      = 3'd1,
        ST_VBACK      = 3'd2,
        ST_LINE_ACT   = 3'd3,
        ST_LINE_BLANK = 3'd4,
        ST_VFRONT     = 3'd5
    } state_t;

    localparam int WAIT_MAX_A = (VSYNC_LEN > VBACK_LEN) ? VSYNC_LEN : VBACK_LEN;
    localparam int WAIT_MAX_B = (H_BLANK > VFRONT_LEN) ? H_BLANK : VFRONT_LEN;
    localparam int WAIT_MAX   = (WAIT_MAX_A > WAIT_MAX_B) ? WAIT_MAX_A : WAIT_MAX_B;
    localparam int WAIT_W     = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam int BYTE_W     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int LINE_W     = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int SUM_W_A    = (BYTE_W > LINE_W) ? BYTE_W : LINE_W;
    localparam int SUM_W      = (SUM_W_A > 8) ? SUM_W_A : 8;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [BYTE_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [LINE_W-1:0]   line_cnt_q, line_cnt_d;
    logic                vsync_q, vsync_d;
    logic                href_q, href_d;
    logic [7:0]          data_q, data_d;
    logic                frame_done_q, frame_done_d;
    logic                busy_q, busy_d;
    logic [SUM_W-1:0]    pattern_sum;
`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
    logic [7:0]          frame_cnt_q, frame_cnt_d;
`endif

    // Next state and counters; the shared wait counter restarts at 0 on every
    // entry into a timed state.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        line_cnt_d   = line_cnt_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.enable) begin
                    state_d    = ST_VSYNC;
                    wait_cnt_d = '0;
                end
            end
            ST_VSYNC: begin
                if (wait_cnt_q == WAIT_W'(VSYNC_LEN - 1)) begin
                    state_d    = ST_VBACK;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_VBACK: begin
                if (wait_cnt_q == WAIT_W'(VBACK_LEN - 1)) begin
                    state_d    = ST_LINE_ACT;
                    byte_cnt_d = '0;
                    line_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_LINE_ACT: begin
                if (byte_cnt_q == BYTE_W'(H_ACTIVE - 1)) begin
                    state_d    = ST_LINE_BLANK;
                    wait_cnt_d = '0;
                end else begin
                    byte_cnt_d = byte_cnt_q + BYTE_W'(1);
                end
            end
            ST_LINE_BLANK: begin
                if (wait_cnt_q == WAIT_W'(H_BLANK - 1)) begin
                    if (line_cnt_q == LINE_W'(V_ACTIVE - 1)) begin
                        state_d    = ST_VFRONT;
                        wait_cnt_d = '0;
                        line_cnt_d = '0;
                    end else begin
                        state_d    = ST_LINE_ACT;
                        byte_cnt_d = '0;
                        line_cnt_d = line_cnt_q + LINE_W'(1);
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_VFRONT: begin
                if (wait_cnt_q == WAIT_W'(VFRONT_LEN - 1)) begin
                    frame_done_d = 1'b1;
                    wait_cnt_d   = '0;
                    state_d      = bus.enable ? ST_VSYNC : ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line
    // up cycle-for-cycle with the state they describe.
    always_comb begin
        vsync_d     = (state_d == ST_VSYNC);
        href_d      = (state_d == ST_LINE_ACT);
        busy_d      = (state_d != ST_IDLE);
`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
        frame_cnt_d = frame_done_d ? (frame_cnt_q + 8'd1) : frame_cnt_q;
        pattern_sum = SUM_W'(byte_cnt_d) + SUM_W'(line_cnt_d) + SUM_W'(frame_cnt_d);
`else
        pattern_sum = SUM_W'(byte_cnt_d) + SUM_W'(line_cnt_d);
`endif
        data_d      = href_d ? 8'(pattern_sum) : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            line_cnt_q   <= '0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            data_q       <= 8'h00;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
            frame_cnt_q  <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            line_cnt_q   <= line_cnt_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            data_q       <= data_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
            frame_cnt_q  <= frame_cnt_d;
`endif
        end
    end

    assign bus.vsync      = vsync_q;
    assign bus.href       = href_q;
    assign bus.data       = data_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;
`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
    assign bus.frame_cnt  = frame_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cam_stream_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_stream_gen
// Description : Self-checking bench for cam_stream_gen against a frame-position
//               reference model; honours CAM_STREAM_GEN_FRAME_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_stream_gen;

    localparam int HA    = 4;
    localparam int HB    = 2;
    localparam int VA    = 3;
    localparam int VS    = 3;
    localparam int VB    = 2;
    localparam int VF    = 2;
    localparam int LINE  = HA + HB;
    localparam int FRAME = VS + VB + VA * LINE + VF;

    logic clk = 1'b0;
    logic reset;

    cam_stream_gen_if bus ();

    cam_stream_gen #(
        .H_ACTIVE   (HA),
        .H_BLANK    (HB),
        .V_ACTIVE   (VA),
        .VSYNC_LEN  (VS),
        .VBACK_LEN  (VB),
        .VFRONT_LEN (VF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a frame is just a position 0..FRAME-1 from its start.
    bit m_active;
    bit m_done;
    int m_pos;
    int m_fc;

    function automatic logic [19:0] model_vec();
        int r, l, b, fc;
        logic vs, hr;
        logic [7:0] d;
        vs = 1'b0; hr = 1'b0; d = 8'h00;
`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
        fc = m_fc;
`else
        fc = 0;
`endif
        if (m_active) begin
            vs = (m_pos < VS);
            r  = m_pos - VS - VB;
            if (r >= 0 && r < VA * LINE) begin
                l = r / LINE;
                b = r % LINE;
                if (b < HA) begin
                    hr = 1'b1;
                    d  = 8'((b + l + fc) % 256);
                end
            end
        end
        return {8'(fc), vs, hr, d, m_done, m_active};
    endfunction

    function automatic logic [19:0] dut_vec();
`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
        return {bus.frame_cnt, bus.vsync, bus.href, bus.data, bus.frame_done, bus.busy};
`else
        return {8'h00, bus.vsync, bus.href, bus.data, bus.frame_done, bus.busy};
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        if (reset) begin
            m_active = 1'b0; m_done = 1'b0; m_pos = 0; m_fc = 0;
        end else if (m_active) begin
            if (m_pos == FRAME - 1) begin
                m_done = 1'b1;
                m_fc   = (m_fc + 1) % 256;
                m_pos  = 0;
                m_active = bus.enable;
            end else begin
                m_done = 1'b0;
                m_pos  = m_pos + 1;
            end
        end else begin
            m_done = 1'b0;
            if (bus.enable) begin
                m_active = 1'b1;
                m_pos    = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.enable = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [19:0] act;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            act = dut_vec();
            n_checks++;
            if (act !== 20'h0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: got %h expected %h", c, act, 20'h0);
            end
            bus.enable = 1'b0;
            step();
        end
    endtask

    task automatic test_single_frame();
        logic [19:0] act, expv;
        logic [7:0]  got_bytes[$];
        int          exp_bytes[12] = '{0, 1, 2, 3, 1, 2, 3, 4, 2, 3, 4, 5};
        int          rises;
        logic        prev_href, e_vs, e_hr, e_done, e_busy;
        rises = 0; prev_href = 1'b0;
        do_reset();
        for (int c = 0; c < 46; c++) begin
            act  = dut_vec();
            expv = model_vec();
            n_checks++;
            if (act !== expv) begin
                n_fail++;
                $display("FAIL single_model cycle %0d: got %h expected %h", c, act, expv);
            end
            e_vs   = (c >= 11 && c <= 13);
            e_hr   = (c >= 16 && c <= 19) || (c >= 22 && c <= 25) || (c >= 28 && c <= 31);
            e_done = (c == 36);
            e_busy = (c >= 11 && c <= 35);
            n_checks++;
            if ({bus.vsync, bus.href, bus.frame_done, bus.busy} !== {e_vs, e_hr, e_done, e_busy}) begin
                n_fail++;
                $display("FAIL single_timing cycle %0d: got vs/hr/done/busy %b%b%b%b expected %b%b%b%b",
                         c, bus.vsync, bus.href, bus.frame_done, bus.busy, e_vs, e_hr, e_done, e_busy);
            end
            if (bus.href === 1'b1) got_bytes.push_back(bus.data);
            if (bus.href === 1'b1 && !prev_href) rises++;
            prev_href  = bus.href;
            bus.enable = (c == 10);
            step();
        end
        n_checks++;
        if (rises != VA) begin
            n_fail++;
            $display("FAIL single_href_rises: got %0d expected %0d", rises, VA);
        end
        n_checks++;
        if (got_bytes.size() != 12) begin
            n_fail++;
            $display("FAIL single_byte_count: got %0d expected 12", got_bytes.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                n_checks++;
                if (got_bytes[i] !== 8'(exp_bytes[i])) begin
                    n_fail++;
                    $display("FAIL single_data byte %0d: got %0d expected %0d", i, got_bytes[i], exp_bytes[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] act, expv;
        int vs_rises[$];
        int dones[$];
        int exp_pts[3] = '{11, 36, 61};
        int base;
        logic prev_vs;
        prev_vs = 1'b0;
`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
        base = 2;
`else
        base = 0;
`endif
        do_reset();
        for (int c = 0; c < 96; c++) begin
            act  = dut_vec();
            expv = model_vec();
            n_checks++;
            if (act !== expv) begin
                n_fail++;
                $display("FAIL b2b_model cycle %0d: got %h expected %h", c, act, expv);
            end
            if (c >= 11 && c <= 85 && bus.busy !== 1'b1) begin
                n_checks++;
                n_fail++;
                $display("FAIL b2b_busy cycle %0d: got %b expected 1", c, bus.busy);
            end
            if (c >= 66 && c <= 69) begin
                n_checks++;
                if (bus.href !== 1'b1 || bus.data !== 8'(base + c - 66)) begin
                    n_fail++;
                    $display("FAIL b2b_frame2_data cycle %0d: got href %b data %0d expected href 1 data %0d",
                             c, bus.href, bus.data, base + c - 66);
                end
            end
`ifdef CAM_STREAM_GEN_FRAME_CNT_EN
            if (c == 35 || c == 36 || c == 61 || c == 86) begin
                n_checks++;
                if (bus.frame_cnt !== 8'((c == 35) ? 0 : (c == 36) ? 1 : (c == 61) ? 2 : 3)) begin
                    n_fail++;
                    $display("FAIL b2b_frame_cnt cycle %0d: got %0d", c, bus.frame_cnt);
                end
            end
`endif
            if (bus.vsync === 1'b1 && !prev_vs) vs_rises.push_back(c);
            if (bus.frame_done === 1'b1) dones.push_back(c);
            prev_vs    = bus.vsync;
            bus.enable = (c >= 10 && c <= 60);
            step();
        end
        n_checks++;
        if (vs_rises.size() != 3 || dones.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_counts: got vsync rises %0d dones %0d expected 3 3", vs_rises.size(), dones.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (vs_rises[i] != exp_pts[i] || dones[i] != exp_pts[i] + FRAME) begin
                    n_fail++;
                    $display("FAIL b2b_cycles frame %0d: got vsync %0d done %0d expected vsync %0d done %0d",
                             i, vs_rises[i], dones[i], exp_pts[i], exp_pts[i] + FRAME);
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        logic [19:0] act, expv;
        int n_vs, n_done, done_at;
        logic prev_vs;
        n_vs = 0; n_done = 0; done_at = -1; prev_vs = 1'b0;
        do_reset();
        for (int c = 0; c < 51; c++) begin
            act  = dut_vec();
            expv = model_vec();
            n_checks++;
            if (act !== expv) begin
                n_fail++;
                $display("FAIL drop_model cycle %0d: got %h expected %h", c, act, expv);
            end
            if (bus.vsync === 1'b1 && !prev_vs) n_vs++;
            if (bus.frame_done === 1'b1) begin n_done++; done_at = c; end
            prev_vs    = bus.vsync;
            bus.enable = (c >= 10 && c <= 19);
            step();
        end
        n_checks++;
        if (n_vs != 1 || n_done != 1 || done_at != 36) begin
            n_fail++;
            $display("FAIL drop_frame: got vsync rises %0d dones %0d done_at %0d expected 1 1 36", n_vs, n_done, done_at);
        end
    endtask

    task automatic test_reset_mid();
        logic [19:0] act, expv;
        int dones[$];
        do_reset();
        for (int c = 0; c < 71; c++) begin
            act  = dut_vec();
            expv = model_vec();
            n_checks++;
            if (act !== expv) begin
                n_fail++;
                $display("FAIL midrst_model cycle %0d: got %h expected %h", c, act, expv);
            end
            if (c == 24) begin
                n_checks++;
                if (act !== 20'h0) begin
                    n_fail++;
                    $display("FAIL midrst_clear cycle %0d: got %h expected %h", c, act, 20'h0);
                end
            end
            if (c >= 46 && c <= 49) begin
                n_checks++;
                if (bus.href !== 1'b1 || bus.data !== 8'(c - 46)) begin
                    n_fail++;
                    $display("FAIL midrst_restart cycle %0d: got href %b data %0d expected href 1 data %0d",
                             c, bus.href, bus.data, c - 46);
                end
            end
            if (bus.frame_done === 1'b1) dones.push_back(c);
            bus.enable = (c == 10) || (c == 40);
            reset      = (c == 23);
            step();
        end
        reset = 1'b0;
        n_checks++;
        if (dones.size() != 1 || dones[0] != 66) begin
            n_fail++;
            $display("FAIL midrst_done: got %0d pulses first at %0d expected 1 at 66",
                     dones.size(), (dones.size() > 0) ? dones[0] : -1);
        end
    endtask

    task automatic test_random();
        logic [19:0] act, expv;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            act  = dut_vec();
            expv = model_vec();
            n_checks++;
            if (act !== expv) begin
                n_fail++;
                $display("FAIL random_model cycle %0d: got %h expected %h", c, act, expv);
            end
            n_checks++;
            if (bus.vsync === 1'b1 && bus.href === 1'b1) begin
                n_fail++;
                $display("FAIL random_exclusive cycle %0d: got vsync 1 href 1 expected not both", c);
            end
            bus.enable = ($urandom_range(0, 3) != 0);
            reset      = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        bus.enable = 1'b0;
        m_active = 1'b0; m_done = 1'b0; m_pos = 0; m_fc = 0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cam_stream_gen.md
Name: cam_stream_gen

Overview:
- Synthesizable OV7670-style frame source: drives vsync/href/data with camera-accurate framing.
- Downstream capture logic sees it exactly as it sees the real sensor, including its edge-detected vsync/href events.
- Used as a sensor stand-in on-board and in simulation, muxed ahead of the capture path, clocked in the pixel-byte (pclk) domain.
- Emits a deterministic byte pattern so captured frames can be checked bit-exactly.

Parameters:
- H_ACTIVE, 1280, data bytes per line while href high (640 px x 2 bytes RGB565); >=1
- H_BLANK, 288, href-low cycles after each line's active bytes; >=1
- V_ACTIVE, 480, lines per frame; >=1
- VSYNC_LEN, 1568, cycles vsync is high; >=1
- VBACK_LEN, 1568, idle cycles between vsync fall and first href rise; >=1
- VFRONT_LEN, 1568, idle cycles after the last line's blank; >=1

Ports:
- clk  input  1  pixel-byte clock
- reset  input  1  synchronous, active-high
- enable  input  1  level; permits starting a new frame
- vsync  output  1  frame sync, active high
- href  output  1  line valid, active high
- data  output  8  pixel byte, valid while href=1, else 0
- frame_done  output  1  one-cycle pulse after each completed frame
- busy  output  1  high from frame start until frame_done

Behaviour:
- One clock; reset is synchronous and active-high.
- All outputs are registered.
- Reset values: vsync=0, href=0, data=0, frame_done=0, busy=0; FSM in IDLE; all counters 0.
- Reset mid-frame aborts immediately: same cycle-after behaviour as power-up reset, with no frame_done.
- FSM states: IDLE -> VSYNC -> VBACK -> LINE_ACT <-> LINE_BLANK -> VFRONT -> (IDLE or VSYNC).
- IDLE: outputs low. If enable=1 in cycle N, vsync=1 and busy=1 from cycle N+1.
- VSYNC: vsync=1 for exactly VSYNC_LEN cycles.
- VBACK: all low except busy, for VBACK_LEN cycles.
- LINE_ACT: href=1 for exactly H_ACTIVE cycles; byte_cnt runs 0..H_ACTIVE-1.
  - data = (byte_cnt + line_cnt) mod 256, with line_cnt 0-based.
- LINE_BLANK: href=0, data=0 for H_BLANK cycles; then line_cnt increments.
  - If line_cnt was V_ACTIVE-1, go to VFRONT; else go to LINE_ACT.
- VFRONT: low for VFRONT_LEN cycles.
- Next cycle after VFRONT (the "done cycle"): frame_done=1 for exactly one cycle.
  - If enable=1 in the last VFRONT cycle, the done cycle is also the first VSYNC cycle (vsync=1, busy stays 1); back-to-back frames have no gap.
  - Otherwise the done cycle is IDLE with busy=0.
- Total frame length: VSYNC_LEN + VBACK_LEN + V_ACTIVE*(H_ACTIVE+H_BLANK) + VFRONT_LEN cycles.
- enable deasserted mid-frame: the current frame completes unchanged. enable is only sampled in IDLE and in the last VFRONT cycle.
- vsync and href are never high in the same cycle.
- href rises exactly V_ACTIVE times per frame.
- Counters are sized by $clog2 of their parameter (minimum 1 bit). Wait counter is shared across VSYNC/VBACK/LINE_BLANK/VFRONT and reloads on every state entry.

Optional Feature:
- Macro CAM_STREAM_GEN_FRAME_CNT_EN.
- Defined:
  - Adds output port frame_cnt[7:0] (reset 0), incremented in the cycle frame_done is asserted; wraps 255->0.
  - Pattern becomes data = (byte_cnt + line_cnt + frame_cnt) mod 256, using the frame_cnt value held during the frame.
- Undefined: no frame_cnt port; pattern as above.

Test Plan:
- All tests use H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, VSYNC_LEN=3, VBACK_LEN=2, VFRONT_LEN=2 (frame = 25 cycles).
- Reset then enable=0 for 20 cycles -> all outputs 0, busy=0.
- enable=1 pulsed in cycle 10 only -> checks below:
  - vsync=1 cycles 11-13.
  - href=1 cycles 16-19, 22-25, 28-31.
  - data lines: 0,1,2,3 / 1,2,3,4 / 2,3,4,5.
  - frame_done=1 only in cycle 36; busy=1 cycles 11-35, 0 at 36.
- enable held high -> second vsync rises in cycle 36, coincident with frame_done; frames repeat every 25 cycles; busy never drops.
- enable dropped in cycle 20, mid-frame -> frame completes identically, frame_done at 36, no second vsync.
- reset asserted in cycle 23 during href -> cycle 24: all outputs 0, no frame_done; enable=1 afterwards starts a clean frame from line 0.
- With CAM_STREAM_GEN_FRAME_CNT_EN, 3 back-to-back frames:
  - frame_cnt = 0, 1, 2, 3 after successive frame_done pulses.
  - Frame 2 line 0 data = 2,3,4,5.
